// File: rtl/trng_pkg.sv
// Shared types and sizes for the TRNG seed collector: FSM state encoding and
// the raw-sample width seen from the ring-oscillator shift register.
package trng_pkg;

    localparam int TRN_W      = 64;
    localparam int SEED_WORDS = 256 / TRN_W;

    typedef enum logic [1:0] {
        WARMUP,
        COLLECT,
        DONE,
        FAIL
    } state_t;

endpackage

// File: rtl/trng_health_rct.sv
// Repetition-count health test: flags samples that repeat the previous one or
// are all-zero/all-one, and raises fail on the REP_LIMIT-th consecutive bad one.
module trng_health_rct
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TRN_W-1:0] sample,
    input  logic             sample_en,
    output logic             sample_ok,
    output logic             fail
);

    localparam int CNT_W = $clog2(REP_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REP_LIMIT - 1);

    logic [TRN_W-1:0] prev_q;
    logic [CNT_W-1:0] bad_cnt_q;

    assign sample_ok = (sample != prev_q) && (sample != '0) && (sample != '1);
    // fail is combinational so the owner can leave collection on the very sample that trips it
    assign fail      = sample_en && !sample_ok && (bad_cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q    <= '0;
            bad_cnt_q <= '0;
        end else if (sample_en) begin
            prev_q    <= sample;
            bad_cnt_q <= sample_ok ? '0 : bad_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/trng_seed_collector.sv
// Samples the TRN shift register every 64 clocks, health-tests and XOR-folds
// the samples into a SEED_W-bit seed offered over a valid/ready handshake.
module trng_seed_collector
    import trng_pkg::*;
#(
    parameter int SEED_W     = SEED_WORDS * TRN_W,
    parameter int FOLD       = 2,
    parameter int WARMUP_CYC = 1024,
    parameter int REP_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       trn,
    output logic [SEED_W-1:0] seed,
    output logic              seed_valid,
    input  logic              seed_ready,
    output logic              health_fail
);

    localparam int N_WORDS = SEED_W / TRN_W;
    localparam int WARM_W  = $clog2(WARMUP_CYC + 1);
    localparam int FOLD_W  = $clog2(FOLD + 1);
    localparam int IDX_W   = $clog2(N_WORDS + 1);
    localparam int SEL_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
    localparam logic [FOLD_W-1:0] FOLD_LAST = FOLD_W'(FOLD - 1);
    localparam logic [IDX_W-1:0]  WORD_LAST = IDX_W'(N_WORDS - 1);

    state_t state_q, state_d;

    logic [5:0]                    phase_q;
    logic [WARM_W-1:0]             warm_cnt_q;
    logic [FOLD_W-1:0]             fold_cnt_q;
    logic [IDX_W-1:0]              word_idx_q;
    logic [TRN_W-1:0]              acc_q;
    logic [TRN_W-1:0]              acc_next;
    logic [N_WORDS-1:0][TRN_W-1:0] seed_q;

    logic sample_en;
    logic sample_ok;
    logic rct_fail;
    logic good;
    logic word_done;
    logic transfer;

    // Samples only count while collecting; phase-63 ticks in DONE are dropped.
    assign sample_en = (state_q == COLLECT) && (phase_q == 6'd63);
    assign good      = sample_en && sample_ok;
    assign word_done = good && (fold_cnt_q == FOLD_LAST);
    assign transfer  = (state_q == DONE) && seed_ready;
    assign acc_next  = acc_q ^ trn;

    trng_health_rct #(
        .REP_LIMIT(REP_LIMIT)
    ) u_health (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample   (trn),
        .sample_en(sample_en),
        .sample_ok(sample_ok),
        .fail     (rct_fail)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= WARMUP;
        else        state_q <= state_d;
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WARMUP:  if (warm_cnt_q == WARM_LAST) state_d = COLLECT;
            COLLECT: begin
                if (rct_fail)                              state_d = FAIL;
                else if (word_done && word_idx_q == WORD_LAST) state_d = DONE;
            end
            DONE:    if (seed_ready) state_d = COLLECT;
            FAIL:    state_d = FAIL;
            default: state_d = WARMUP;
        endcase
    end

    // NOTE: the seed register is reset explicitly because its contents must
    // read as zero after reset, transfer and health failure, not just be ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q    <= '0;
            warm_cnt_q <= '0;
            fold_cnt_q <= '0;
            word_idx_q <= '0;
            acc_q      <= '0;
            seed_q     <= '0;
        end else begin
            if (state_q == WARMUP)    phase_q <= '0;
            else if (state_q != FAIL) phase_q <= phase_q + 6'd1;

            if (state_q == WARMUP && warm_cnt_q != WARM_LAST)
                warm_cnt_q <= warm_cnt_q + WARM_W'(1);

            if (word_done) begin
                seed_q[word_idx_q[SEL_W-1:0]] <= acc_next;
                acc_q      <= '0;
                fold_cnt_q <= '0;
                word_idx_q <= word_idx_q + IDX_W'(1);
            end else if (good) begin
                acc_q      <= acc_next;
                fold_cnt_q <= fold_cnt_q + FOLD_W'(1);
            end

            if (transfer) begin
                seed_q     <= '0;
                word_idx_q <= '0;
            end

            if (rct_fail) begin
                seed_q     <= '0;
                acc_q      <= '0;
                fold_cnt_q <= '0;
                word_idx_q <= '0;
            end
        end
    end

    assign seed        = seed_q;
    assign seed_valid  = (state_q == DONE);
    assign health_fail = (state_q == FAIL);

endmodule

// File: tb/tb_trng_seed_collector.sv
// Directed-sequence bench with random TRN data, checked every cycle against a
// spec-level model built from edge counts and a queue of accepted samples.
module tb_trng_seed_collector;

    localparam int W = 1024;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  trn = '0;
    logic [255:0] seed;
    logic         seed_valid;
    logic         seed_ready = 1'b0;
    logic         health_fail;

    trng_seed_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trn        (trn),
        .seed       (seed),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int           m_cyc = 0;
    bit           m_valid = 0;
    bit           m_failed = 0;
    bit           m_seed_known = 0;
    logic [255:0] m_seed = '0;
    logic [63:0]  m_prev = '0;
    int           m_bad = 0;
    logic [63:0]  goodq[$];
    logic [63:0]  dirq[$];
    bit           stuck = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_sample_cyc(input int c);
        return (c > W) && (((c - W) % 64) == 0);
    endfunction

    function automatic int next_sample_after(input int c);
        if (c < W) return W + 64;
        return W + 64 * ((c - W) / 64 + 1);
    endfunction

    task automatic model_step(input logic rst_v, input logic [63:0] v, input logic rdy);
        bit bad;
        if (!rst_v) begin
            m_cyc = 0; m_valid = 0; m_failed = 0; m_seed = '0; m_seed_known = 1;
            m_prev = '0; m_bad = 0; goodq.delete();
        end else begin
            m_cyc++;
            if (m_failed) begin
            end else if (m_valid) begin
                if (rdy) begin
                    m_valid = 0; m_seed = '0; m_seed_known = 1;
                end
            end else if (is_sample_cyc(m_cyc)) begin
                bad = (v === m_prev) || (v == 64'h0) || (v == {64{1'b1}});
                m_prev = v;
                if (bad) begin
                    m_bad++;
                    if (m_bad == 4) begin
                        m_failed = 1; m_seed = '0; m_seed_known = 1; goodq.delete();
                    end
                end else begin
                    m_bad = 0;
                    goodq.push_back(v);
                    if (goodq.size() % 2 == 0) m_seed_known = 0;
                    if (goodq.size() == 8) begin
                        for (int i = 0; i < 4; i++)
                            m_seed[64*i +: 64] = goodq[2*i] ^ goodq[2*i+1];
                        m_valid = 1; m_seed_known = 1; goodq.delete();
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic rst_v, input logic rdy);
        logic [63:0] v;
        if (rst_v && is_sample_cyc(m_cyc + 1) && !m_valid && !m_failed && dirq.size() > 0)
            v = dirq.pop_front();
        else if (stuck)
            v = '0;
        else
            v = {$urandom, $urandom};
        trn = v;
        seed_ready = rdy;
        rst_n = rst_v;
        @(posedge clk);
        model_step(rst_v, v, rdy);
        #1;
        check("seed_valid", seed_valid, m_valid);
        check("health_fail", health_fail, m_failed);
        if (m_seed_known) check("seed", seed, m_seed);
    endtask

    task automatic wait_sig(input bit want_fail, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(1'b1, 1'b0);
            if ((want_fail ? health_fail : seed_valid) === 1'b1) begin
                at = m_cyc;
                break;
            end
        end
        if (at < 0) begin
            if (want_fail) check("wait_health_fail", health_fail, 1);
            else           check("wait_seed_valid", seed_valid, 1);
        end
    endtask

    initial begin
        logic [63:0]  s[8];
        logic [63:0]  a;
        logic [255:0] held;
        int           at;
        int           t_x;

        // 1/2: reset, warm-up, directed samples A..H folded pairwise
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("rst_seed", seed, '0);
        for (int i = 0; i < 8; i++) begin
            s[i] = {$urandom, $urandom};
            dirq.push_back(s[i]);
        end
        wait_sig(1'b0, 2000, at);
        check("first_valid_cyc", at, W + 512);
        check("seed_fold", seed, {s[6] ^ s[7], s[4] ^ s[5], s[2] ^ s[3], s[0] ^ s[1]});
        held = seed;
        repeat (100) tick(1'b1, 1'b0);
        check("seed_held", seed, held);
        check("valid_held", seed_valid, 1);

        // 3: transfer, then a fresh seed on the free-running phase
        tick(1'b1, 1'b1);
        t_x = m_cyc;
        check("xfer_valid", seed_valid, 0);
        check("xfer_seed", seed, '0);
        wait_sig(1'b0, 700, at);
        check("relatency", at, next_sample_after(t_x) + 7 * 64);

        // 4: one repeated sample delays the seed by one sample slot
        tick(1'b1, 1'b1);
        t_x = m_cyc;
        a = {$urandom, $urandom};
        dirq.push_back(a);
        dirq.push_back(a);
        for (int i = 0; i < 7; i++) dirq.push_back({$urandom, $urandom});
        wait_sig(1'b0, 800, at);
        check("repeat_latency", at, next_sample_after(t_x) + 8 * 64);
        check("repeat_no_fail", health_fail, 0);

        // 5: stuck-at-zero source trips the health test on the 4th bad sample
        tick(1'b1, 1'b1);
        t_x = m_cyc;
        stuck = 1;
        wait_sig(1'b1, 600, at);
        check("fail_cyc", at, next_sample_after(t_x) + 3 * 64);
        check("fail_no_valid", seed_valid, 0);
        repeat (50) tick(1'b1, 1'b1);
        check("fail_sticky", health_fail, 1);
        stuck = 0;
        tick(1'b0, 1'b0);
        check("rst_clears_fail", health_fail, 0);
        check("rst_clears_valid", seed_valid, 0);

        // 6: reset after five good samples discards the partial seed
        for (int i = 0; i < 2000 && goodq.size() < 5; i++) tick(1'b1, 1'b0);
        check("partial_no_valid", seed_valid, 0);
        tick(1'b0, 1'b0);
        wait_sig(1'b0, 2000, at);
        check("post_rst_latency", at, W + 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
